// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcode and state encodings shared by the calculator datapath
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_divide(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MUL) || is_divide(op);
    endfunction

endpackage

// File: rtl/restoring_div.sv
// rtl/restoring_div.sv - one restoring-division step per enabled cycle, driven by the core's counter
module restoring_div #(
    parameter int W  = 4,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [CW-1:0] i_cnt,
    input  logic [W-1:0]  i_dividend,
    input  logic [W-1:0]  i_divisor,
    output logic [W-1:0]  o_quot_nxt,
    output logic [W:0]    o_rem_nxt
);

    logic [W-1:0]  r_dvd;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_rem;
    logic [CW-1:0] w_idx;
    logic [W:0]    w_shift;
    logic [W:0]    w_sub;
    logic          w_ge;

    // Step i brings down dividend bit W-1-i and decides quotient bit W-1-i.
    assign w_idx   = CW'(W - 1) - i_cnt;
    assign w_shift = {r_rem, r_dvd[w_idx]};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});
    assign w_sub   = w_shift - {1'b0, i_divisor};
    assign o_rem_nxt = w_ge ? w_sub : w_shift;

    always_comb begin
        o_quot_nxt        = r_quot;
        o_quot_nxt[w_idx] = w_ge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
        end else if (i_load) begin
            r_dvd  <= i_dividend;
            r_quot <= '0;
            r_rem  <= '0;
        end else if (i_en) begin
            r_quot <= o_quot_nxt;
            r_rem  <= o_rem_nxt[W-1:0];
        end
    end

endmodule

// File: rtl/seq_calc_core.sv
// rtl/seq_calc_core.sv - multi-cycle arithmetic core with held result and one-cycle done pulse
module seq_calc_core
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     opp,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           neg,
    output logic           err
);

    localparam int RW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_mplier;
    logic [2:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_acc;
    logic [RW-1:0] r_mcand;
    logic [RW-1:0] r_result;
    logic          r_neg;
    logic          r_err;

    logic [RW-1:0] w_acc_nxt;
    logic [RW-1:0] w_res;
    logic          w_neg;
    logic          w_err;
    logic          w_latch;
    logic          w_iter;
    logic          w_fin;
    logic          w_div0;
    logic [W-1:0]  w_quot;
    logic [W:0]    w_rem;

    assign w_div0    = is_divide(r_op) && (r_b == '0);
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    restoring_div #(.W(W), .CW(CW)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_latch),
        .i_en       (w_iter),
        .i_cnt      (r_cnt),
        .i_dividend (a),
        .i_divisor  (r_b),
        .o_quot_nxt (w_quot),
        .o_rem_nxt  (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_iter  = 1'b0;
        w_fin   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_latch = 1'b1;
                    w_next  = ST_CALC;
                end
            end
            ST_CALC: begin
                // Divide by zero skips iteration and finishes like a single-cycle op.
                if (is_iterative(r_op) && !w_div0) begin
                    w_iter = 1'b1;
                    if (r_cnt == LAST) begin
                        w_fin  = 1'b1;
                        w_next = ST_DONE;
                    end
                end else begin
                    w_fin  = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_neg = 1'b0;
        w_err = 1'b0;
        case (r_op)
            OP_ADD: w_res = {{(RW-W){1'b0}}, r_a} + {{(RW-W){1'b0}}, r_b};
            OP_SUB: begin
                if (r_a >= r_b) begin
                    w_res = {{(RW-W){1'b0}}, r_a - r_b};
                end else begin
                    w_res = {{(RW-W){1'b0}}, r_b - r_a};
                    w_neg = 1'b1;
                end
            end
            OP_MUL: w_res = w_acc_nxt;
            OP_DIV: begin
                w_res = w_div0 ? '1 : {{(RW-W){1'b0}}, w_quot};
                w_err = w_div0;
            end
            OP_MOD: begin
                w_res = w_div0 ? '1 : {{(RW-W-1){1'b0}}, w_rem};
                w_err = w_div0;
            end
            OP_AND: w_res = {{(RW-W){1'b0}}, r_a & r_b};
            OP_OR:  w_res = {{(RW-W){1'b0}}, r_a | r_b};
            OP_XOR: w_res = {{(RW-W){1'b0}}, r_a ^ r_b};
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_latch) begin
                r_a      <= a;
                r_b      <= b;
                r_op     <= opp;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= {{(RW-W){1'b0}}, a};
                r_mplier <= b;
            end else if (w_iter) begin
                r_cnt    <= r_cnt + 1'b1;
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            // Outputs change only on the edge that enters DONE.
            if (w_fin) begin
                r_result <= w_res;
                r_neg    <= w_neg;
                r_err    <= w_err;
            end
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;
    assign neg    = r_neg;
    assign err    = r_err;

endmodule

// File: tb/tb_seq_calc_core.sv
// tb/tb_seq_calc_core.sv - self-checking bench for seq_calc_core
module tb_seq_calc_core;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opp;
    logic         busy;
    logic         done;
    logic [2*W-1:0] result;
    logic         neg;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rec_en = 0;
    int done_t[$];

    seq_calc_core #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .opp    (opp),
        .busy   (busy),
        .done   (done),
        .result (result),
        .neg    (neg),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic result plus the number of edges from accept to DONE.
    function automatic void model_calc(input logic [3:0] x, input logic [3:0] y, input logic [2:0] op,
                                       output logic [7:0] r, output logic ng, output logic er,
                                       output int lat);
        int ix;
        int iy;
        ix = int'(x);
        iy = int'(y);
        ng = 1'b0;
        er = 1'b0;
        lat = 1;
        r = 8'd0;
        case (op)
            3'd0: r = 8'(ix + iy);
            3'd1: begin
                if (ix >= iy) r = 8'(ix - iy);
                else begin r = 8'(iy - ix); ng = 1'b1; end
            end
            3'd2: begin r = 8'(ix * iy); lat = W; end
            3'd3: begin
                if (iy == 0) begin r = 8'hFF; er = 1'b1; end
                else begin r = 8'(ix / iy); lat = W; end
            end
            3'd4: begin
                if (iy == 0) begin r = 8'hFF; er = 1'b1; end
                else begin r = 8'(ix % iy); lat = W; end
            end
            3'd5: r = {4'd0, x & y};
            3'd6: r = {4'd0, x | y};
            default: r = {4'd0, x ^ y};
        endcase
    endfunction

    // m_cnt: cycles of busy remaining; done is expected while it is 1.
    int         m_cnt;
    logic [7:0] m_res;
    logic       m_neg;
    logic       m_err;
    logic [7:0] m_pres;
    logic       m_pneg;
    logic       m_perr;

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] tr;
        logic tn;
        logic te;
        int tl;
        if (!rst_n) begin
            m_cnt <= 0;
            m_res <= 8'd0;
            m_neg <= 1'b0;
            m_err <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                model_calc(a, b, opp, tr, tn, te, tl);
                m_pres <= tr;
                m_pneg <= tn;
                m_perr <= te;
                m_cnt  <= tl + 1;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_res <= m_pres;
                m_neg <= m_pneg;
                m_err <= m_perr;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        chk("busy",   32'(busy),   32'(m_cnt != 0));
        chk("done",   32'(done),   32'(m_cnt == 1));
        chk("result", 32'(result), 32'(m_res));
        chk("neg",    32'(neg),    32'(m_neg));
        chk("err",    32'(err),    32'(m_err));
        if (rec_en && done) done_t.push_back(cyc);
    end

    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic [2:0] top,
                          input logic [7:0] eres, input logic eneg, input logic eerr,
                          input int elat, input bit poke);
        int n;
        bit seen;
        a = ta;
        b = tb_;
        opp = top;
        start = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                a = ~ta;
                b = ~tb_;
                opp = ~top;
            end
            start = poke && (n == 2);
            if (done) seen = 1;
        end
        start = 1'b0;
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL done_timeout op=%0d actual=none required=done within 20 cycles", top);
        end else begin
            chk("latency", 32'(n), 32'(elat));
            chk("lit_result", 32'(result), 32'(eres));
            chk("lit_neg", 32'(neg), 32'(eneg));
            chk("lit_err", 32'(err), 32'(eerr));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        opp = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd9,  4'd6,  3'd0, 8'd15,  1'b0, 1'b0, 2, 1'b0);
        run_op(4'd3,  4'd7,  3'd1, 8'd4,   1'b1, 1'b0, 2, 1'b0);
        run_op(4'd7,  4'd3,  3'd1, 8'd4,   1'b0, 1'b0, 2, 1'b0);
        run_op(4'd15, 4'd15, 3'd2, 8'hE1,  1'b0, 1'b0, 5, 1'b1);
        run_op(4'd13, 4'd4,  3'd3, 8'd3,   1'b0, 1'b0, 5, 1'b0);
        run_op(4'd13, 4'd4,  3'd4, 8'd1,   1'b0, 1'b0, 5, 1'b0);
        run_op(4'd13, 4'd0,  3'd3, 8'hFF,  1'b0, 1'b1, 2, 1'b0);
        run_op(4'd9,  4'd0,  3'd4, 8'hFF,  1'b0, 1'b1, 2, 1'b0);
        run_op(4'd12, 4'd10, 3'd5, 8'd8,   1'b0, 1'b0, 2, 1'b0);
        run_op(4'd12, 4'd10, 3'd6, 8'd14,  1'b0, 1'b0, 2, 1'b0);
        run_op(4'd12, 4'd10, 3'd7, 8'd6,   1'b0, 1'b0, 2, 1'b0);
        run_op(4'd0,  4'd0,  3'd2, 8'd0,   1'b0, 1'b0, 5, 1'b0);

        // start held high, opcode switched right after each accept: ADD, MUL, ADD, MUL
        done_t.delete();
        rec_en = 1;
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opp = (i % 2 == 0) ? 3'd0 : 3'd2;
            repeat ((i % 2 == 0) ? 3 : 6) @(negedge clk);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        rec_en = 0;
        chk("tput_pulses", 32'(done_t.size()), 32'd4);
        for (int i = 1; i < done_t.size(); i++)
            chk("tput_spacing", 32'(done_t[i] - done_t[i-1]), (i % 2 == 1) ? 32'd6 : 32'd3);
        chk("tput_last_result", 32'(result), 32'd15);

        // reset two cycles into a multiply
        a = 4'd15;
        b = 4'd15;
        opp = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_neg", 32'(neg), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op(4'd2, 4'd5, 3'd2, 8'd10, 1'b0, 1'b0, 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_calc_core.md
# seq_calc_core

Multi-cycle registered arithmetic core for the 4-bit calculator datapath. Latches two operands and an opcode on a `start` request, computes add/sub/logic results in one cycle and multiply/divide/modulo iteratively, then presents a held result with a one-cycle `done` pulse. It sits directly upstream of the binary-to-BCD converter. `done` drives the converter's `en`, and `result`, zero-extended, drives its binary input.

## Interface
- `W`, default 4: operand width.
- `RW`, default 2*W: result width. Not overridable independently.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: operation request; sampled only in IDLE.
- `a` in W: operand A, unsigned.
- `b` in W: operand B, unsigned.
- `opp` in 3: opcode, sampled with `start`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse; result, `neg` and `err` are valid and updated.
- `result` out RW: unsigned magnitude; held until the next `done`.
- `neg` out 1: SUB result is negative (B > A).
- `err` out 1: divide or modulo by zero.

## Operation
- Opcodes:
  - 000 ADD: `result` = A+B, zero-extended.
  - 001 SUB: if A>=B, `result`=A-B and `neg`=0; else `result`=B-A and `neg`=1.
  - 010 MUL: shift-add, W iterations, full 2W-bit product.
  - 011 DIV: restoring division, W iterations; `result` = quotient, zero-extended.
  - 100 MOD: same datapath as DIV; `result` = remainder, zero-extended.
  - 101 AND, 110 OR, 111 XOR: bitwise, zero-extended.
- `neg` is 0 and `err` is 0 for every opcode except where stated above.
- States:
  - IDLE: on `start`=1, latch a, b and opp, clear the iteration counter, go to CALC.
  - CALC, single-cycle ops: register the result and go to DONE.
  - CALC, MUL/DIV/MOD: run one iteration per cycle; go to DONE when counter reaches W-1.
  - DONE: `done`=1; go to IDLE unconditionally.
- DIV or MOD with B=0: no iteration. CALC lasts one cycle; `result` = all ones (0xFF at W=4) and `err`=1.
- `start` in CALC or DONE is ignored and not queued. `a`, `b` and `opp` changing after the latch edge have no effect.
- `result`, `neg` and `err` update only on the edge that enters DONE. They are otherwise stable, so the downstream stage may sample them at any time after `done`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `result`=0, `neg`=0, `err`=0.
- `rst_n` low at any time, including mid-iteration, forces the reset values immediately without waiting for a clock edge. The operation is abandoned and no `done` is produced.
- Start sampled at edge k:
  - `busy` is high from after edge k.
  - Single-cycle ops and divide-by-zero: DONE entered at edge k+1; `done` high for the cycle after k+1.
  - MUL/DIV/MOD: DONE entered at edge k+W.
- DONE→IDLE at the following edge; `busy` falls there.
- Earliest next accepted `start`:
  - single-cycle op: edge k+3;
  - MUL/DIV/MOD: edge k+W+2.
- `start` held high continuously yields back-to-back operations at that rate.

## Structure
- Shared package `calc_pkg`:
  - opcode localparams OP_ADD … OP_XOR;
  - state encoding ST_IDLE, ST_CALC, ST_DONE.
- The top-level calculator imports the same opcode constants.
- One sub-module, `restoring_div`, holds the W-step quotient/remainder shift register and trial subtract. It is enabled by the core and shares the core's iteration counter.
- Multiply stays inline in the core: accumulator plus shifted multiplicand.

## Test plan
- **ADD:** a=9, b=6, opp=000, start one cycle → `done` one cycle after edge k+1, `result`=15, `neg`=0, `err`=0; `busy` high exactly 2 cycles.
- **SUB:** a=3, b=7, opp=001 → `result`=4, `neg`=1. Then a=7, b=3 → `result`=4, `neg`=0.
- **MUL:** a=15, b=15, opp=010 → `result`=225 (0xE1); `done` after edge k+4; `start` pulsed during CALC is ignored.
- **DIV/MOD:**
  - a=13, b=4, DIV → `result`=3.
  - a=13, b=4, MOD → `result`=1.
  - a=13, b=0, DIV → `result`=0xFF, `err`=1, `done` after edge k+1.
- **Throughput:** `start` held high with alternating ADD/MUL → `done` pulses spaced 3 and 6 cycles; `result` constant between pulses.
- **Reset mid-operation:** `rst_n` low two cycles into a MUL → all outputs 0 immediately, no `done`. After release, a=2, b=5 MUL → `result`=10.
